my_mod: RTL and testbench

MY_MOD -- requirements
Module: my_mod

---
 rtl/my_mod.sv | 168 ++++++++++++++++
 tb/tb_my_mod.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/my_mod.sv
// ---------------------------------------------------------------------------
// my_mod -- single-cycle 9-bit accumulator with add / xor / shift operations
//
// An operation presented with valid_in is applied to the accumulator on the
// same rising edge; the new value appears on x together with a one-cycle
// valid_out pulse. A sticky overflow flag records carries out of the add and
// ones lost off the top of the left shift.
//
// Parameters
//   X : left-shift amount used by op 2'b10 (0..8)
//   Y : arithmetic right-shift amount used by op 2'b11 (0..8)
//
// Ports
//   clk       in   rising-edge clock for all state
//   reset     in   synchronous active-high reset
//   foo[8:0]  in   operand (used by add and xor only)
//   op[1:0]   in   00 add, 01 xor, 10 shl X, 11 ashr Y
//   valid_in  in   qualifies foo/op
//   clear     in   synchronous accumulator/overflow clear
//   x[8:0]    out  registered accumulator value
//   valid_out out  one-cycle pulse when x was updated by an operation
//   ovf       out  sticky overflow flag
//   zero      out  x == 0, decoded from the accumulator register
//
// Build option
//   MY_MOD_SAT_EN : when defined, add and shl saturate to 9'h1FF on
//                   overflow instead of wrapping modulo 512.
// ---------------------------------------------------------------------------
module my_mod #(
    parameter int X = 1,
    parameter int Y = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] foo,
    input  logic [1:0] op,
    input  logic       valid_in,
    input  logic       clear,
    output logic [8:0] x,
    output logic       valid_out,
    output logic       ovf,
    output logic       zero
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_XOR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ASHR = 2'b11;

    localparam logic [8:0] ACC_MAX = 9'h1FF;

    logic [8:0] acc_reg;
    logic [8:0] acc_next;
    logic       ovf_reg;
    logic       ovf_next;
    logic       valid_reg;
    logic       valid_next;

    // -----------------------------------------------------------------------
    // Datapath for each operation, computed in parallel from acc_reg
    // -----------------------------------------------------------------------
    logic [9:0] add_sum;
    logic       add_carry;
    logic [8:0] xor_res;
    logic [8:0] shl_res;
    logic [8:0] shl_lost_vec;
    logic       shl_lost;
    logic [8:0] ashr_res;

    assign add_sum   = {1'b0, acc_reg} + {1'b0, foo};
    assign add_carry = add_sum[9];
    assign xor_res   = acc_reg ^ foo;

    // Shifts are by elaboration-time constants, so each result bit is just a
    // wire to a fixed source bit (or a fill value).
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi = gi + 1) begin : g_shift
            // Left shift: bit gi comes from gi-X, zero-filled below X.
            if (gi >= X) begin : g_shl_src
                assign shl_res[gi] = acc_reg[gi-X];
            end else begin : g_shl_fill
                assign shl_res[gi] = 1'b0;
            end

            // Bits at positions >= 9-X fall off the top during the shift.
            if (gi >= 9 - X) begin : g_shl_lost
                assign shl_lost_vec[gi] = acc_reg[gi];
            end else begin : g_shl_kept
                assign shl_lost_vec[gi] = 1'b0;
            end

            // Arithmetic right shift: bit 8 is the sign and is replicated.
            if (gi + Y <= 8) begin : g_ashr_src
                assign ashr_res[gi] = acc_reg[gi+Y];
            end else begin : g_ashr_sign
                assign ashr_res[gi] = acc_reg[8];
            end
        end
    endgenerate

    assign shl_lost = |shl_lost_vec;

    // -----------------------------------------------------------------------
    // Next-state selection
    // -----------------------------------------------------------------------
    always_comb begin
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        valid_next = 1'b0;

        if (clear) begin
            // An operation arriving with clear is intentionally discarded.
            acc_next = 9'd0;
            ovf_next = 1'b0;
        end else if (valid_in) begin
            valid_next = 1'b1;
            case (op)
                OP_ADD: begin
`ifdef MY_MOD_SAT_EN
                    acc_next = add_carry ? ACC_MAX : add_sum[8:0];
`else
                    acc_next = add_sum[8:0];
`endif
                    ovf_next = ovf_reg | add_carry;
                end
                OP_XOR: begin
                    acc_next = xor_res;
                end
                OP_SHL: begin
`ifdef MY_MOD_SAT_EN
                    acc_next = shl_lost ? ACC_MAX : shl_res;
`else
                    acc_next = shl_res;
`endif
                    ovf_next = ovf_reg | shl_lost;
                end
                OP_ASHR: begin
                    acc_next = ashr_res;
                end
                default: begin
                    acc_next = acc_reg;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers; reset takes priority over clear and valid_in.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg   <= 9'd0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            valid_reg <= valid_next;
        end
    end

    assign x         = acc_reg;
    assign ovf       = ovf_reg;
    assign valid_out = valid_reg;
    assign zero      = (acc_reg == 9'd0);

endmodule

// File: tb/tb_my_mod.sv
// ---------------------------------------------------------------------------
// tb_my_mod -- self-checking bench for my_mod (X=1, Y=2).
// Table of per-cycle vectors with hand-computed expectations, followed by a
// hand-written back-to-back pulse-count sequence. Expected values follow the
// saturating variant when MY_MOD_SAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_my_mod;

`ifdef MY_MOD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] foo = 9'd0;
    logic [1:0] op = 2'b00;
    logic       valid_in = 1'b0;
    logic       clear = 1'b0;
    logic [8:0] x;
    logic       valid_out;
    logic       ovf;
    logic       zero;

    int checks = 0;
    int errors = 0;

    my_mod #(.X(1), .Y(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .foo       (foo),
        .op        (op),
        .valid_in  (valid_in),
        .clear     (clear),
        .x         (x),
        .valid_out (valid_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       vin;
        logic [1:0] op;
        logic [8:0] foo;
        logic [8:0] ex;
        logic       ev;
        logic       eo;
        logic       ez;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rst, logic clr, logic vin, logic [1:0] o,
                                logic [8:0] f, logic [8:0] ex, logic ev,
                                logic eo, logic ez);
        vec_t v;
        v.rst = rst; v.clr = clr; v.vin = vin; v.op = o; v.foo = f;
        v.ex = ex; v.ev = ev; v.eo = eo; v.ez = ez;
        return v;
    endfunction

    task automatic check(string name, int idx, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic clr, logic vin, logic [1:0] o, logic [8:0] f);
        reset = rst; clear = clr; valid_in = vin; op = o; foo = f;
    endtask

    initial begin
        int pulses;

        //            rst  clr  vin  op     foo     x                          vo   ovf  zero
        vecs[0]  = mk(1,   0,   0,   2'b00, 9'h000, 9'h000,                    0,   0,   1);
        vecs[1]  = mk(1,   0,   1,   2'b00, 9'h009, 9'h000,                    0,   0,   1);
        vecs[2]  = mk(0,   0,   1,   2'b00, 9'h005, 9'h005,                    1,   0,   0);
        vecs[3]  = mk(0,   0,   0,   2'b00, 9'h0AA, 9'h005,                    0,   0,   0);
        vecs[4]  = mk(0,   0,   1,   2'b01, 9'h1F5, 9'h1F0,                    1,   0,   0);
        vecs[5]  = mk(0,   0,   1,   2'b00, 9'h020, SAT ? 9'h1FF : 9'h010,     1,   1,   0);
        vecs[6]  = mk(0,   0,   0,   2'b00, 9'h020, SAT ? 9'h1FF : 9'h010,     0,   1,   0);
        vecs[7]  = mk(0,   0,   1,   2'b01, 9'h000, SAT ? 9'h1FF : 9'h010,     1,   1,   0);
        vecs[8]  = mk(0,   1,   0,   2'b00, 9'h000, 9'h000,                    0,   0,   1);
        vecs[9]  = mk(0,   0,   1,   2'b00, 9'h0C0, 9'h0C0,                    1,   0,   0);
        vecs[10] = mk(0,   0,   1,   2'b10, 9'h1FF, 9'h180,                    1,   0,   0);
        vecs[11] = mk(0,   0,   1,   2'b10, 9'h000, SAT ? 9'h1FF : 9'h100,     1,   1,   0);
        vecs[12] = mk(0,   1,   1,   2'b00, 9'h007, 9'h000,                    0,   0,   1);
        vecs[13] = mk(0,   0,   1,   2'b01, 9'h100, 9'h100,                    1,   0,   0);
        vecs[14] = mk(0,   0,   1,   2'b11, 9'h0FF, 9'h1C0,                    1,   0,   0);
        vecs[15] = mk(0,   0,   1,   2'b01, 9'h1C0, 9'h000,                    1,   0,   1);
        vecs[16] = mk(0,   0,   1,   2'b00, 9'h001, 9'h001,                    1,   0,   0);
        vecs[17] = mk(0,   0,   1,   2'b00, 9'h001, 9'h002,                    1,   0,   0);
        vecs[18] = mk(0,   0,   1,   2'b00, 9'h001, 9'h003,                    1,   0,   0);
        vecs[19] = mk(0,   0,   1,   2'b00, 9'h001, 9'h004,                    1,   0,   0);
        vecs[20] = mk(0,   0,   0,   2'b00, 9'h001, 9'h004,                    0,   0,   0);
        vecs[21] = mk(0,   0,   1,   2'b11, 9'h000, 9'h001,                    1,   0,   0);
        vecs[22] = mk(0,   0,   1,   2'b00, 9'h1FF, SAT ? 9'h1FF : 9'h000,     1,   1,   SAT ? 1'b0 : 1'b1);
        vecs[23] = mk(1,   1,   1,   2'b00, 9'h007, 9'h000,                    0,   0,   1);
        vecs[24] = mk(0,   0,   1,   2'b00, 9'h1FF, 9'h1FF,                    1,   0,   0);
        vecs[25] = mk(0,   0,   1,   2'b00, 9'h001, SAT ? 9'h1FF : 9'h000,     1,   1,   SAT ? 1'b0 : 1'b1);
        vecs[26] = mk(0,   0,   1,   2'b01, 9'h0F0, SAT ? 9'h10F : 9'h0F0,     1,   1,   0);
        vecs[27] = mk(0,   0,   1,   2'b10, 9'h000, SAT ? 9'h1FF : 9'h1E0,     1,   1,   0);

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].vin, vecs[i].op, vecs[i].foo);
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%b clr=%b vin=%b op=%b foo=%h -> x=%h vo=%b ovf=%b zero=%b",
                     i, vecs[i].rst, vecs[i].clr, vecs[i].vin, vecs[i].op, vecs[i].foo,
                     x, valid_out, ovf, zero);
            check("x",         i, x,                 vecs[i].ex);
            check("valid_out", i, {8'd0, valid_out}, {8'd0, vecs[i].ev});
            check("ovf",       i, {8'd0, ovf},       {8'd0, vecs[i].eo});
            check("zero",      i, {8'd0, zero},      {8'd0, vecs[i].ez});
            @(negedge clk);
        end

        // Back-to-back adds: exactly four valid_out pulses, then x=4.
        drive(1, 0, 0, 2'b00, 9'h000);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 9'h000);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drive(0, 0, 1, 2'b00, 9'h001);
            else       drive(0, 0, 0, 2'b00, 9'h001);
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
            $display("burst cycle %0d: x=%h vo=%b", c, x, valid_out);
            @(negedge clk);
        end
        check("burst_pulses", 100, pulses[8:0], 9'd4);
        check("burst_x",      100, x,           9'h004);
        check("burst_ovf",    100, {8'd0, ovf}, 9'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
